// File: rtl/platform_reset_pkg.sv
// Shared types for the platform reset sequencer: FSM state encoding
// (also exported on the debug port) and the relock counter width.
package platform_reset_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST    = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SDRAM_INIT = 3'd2,
        ST_RUN        = 3'd3
    } seq_state_t;

    localparam int RELOCK_CNT_W = 8;

endpackage

// File: rtl/platform_sync_2ff.sv
// One-bit two-flop synchronizer with a synchronous active-low clear.
// Output resets to 0 so a "locked" style input reads deasserted after reset.
module platform_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/platform_pll_reset_sequencer.sv
// Reset sequencer behind the system PLL: pulses the PLL reset, qualifies lock,
// then releases the SDRAM-controller reset and the system reset in order.
module platform_pll_reset_sequencer
    import platform_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SDRAM_INIT_CYCLES  = 10000,
    parameter int RELOCK_TIMEOUT     = 1048576,
    parameter int CNT_W              = 21
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    output logic                    pll_rst,
    output logic                    sdram_reset_n,
    output logic                    sys_reset_n,
    output logic                    seq_ready,
    output logic [RELOCK_CNT_W-1:0] relock_count,
    output logic [2:0]              seq_state
);

    localparam logic [CNT_W-1:0] PLL_RST_C = CNT_W'(PLL_RST_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] INIT_C    = CNT_W'(SDRAM_INIT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(RELOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic locked_s;

    seq_state_t              state_reg,  state_next;
    logic [CNT_W-1:0]        cnt_reg,    cnt_next;
    logic [CNT_W-1:0]        tmo_reg,    tmo_next;
    logic [RELOCK_CNT_W-1:0] relock_reg, relock_next;
    logic [CNT_W-1:0]        stable_cnt;
    logic [CNT_W-1:0]        tmo_cnt;
    logic                    pll_rst_reg;
    logic                    sdram_reset_n_reg;
    logic                    sys_reset_n_reg;
    logic                    seq_ready_reg;

    platform_sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tmo_next    = tmo_reg;
        relock_next = relock_reg;
        stable_cnt  = '0;
        tmo_cnt     = '0;

        case (state_reg)
            ST_PLL_RST: begin
                if (cnt_reg >= PLL_RST_C) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                    tmo_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                // cnt_reg is the consecutive-lock run length in this state
                stable_cnt = locked_s ? (cnt_reg + CNT_ONE) : '0;
                tmo_cnt    = tmo_reg + CNT_ONE;
                cnt_next   = stable_cnt;
                tmo_next   = tmo_cnt;
                if (stable_cnt == STABLE_C) begin
                    state_next = ST_SDRAM_INIT;
                    cnt_next   = '0;
                    tmo_next   = '0;
                end else if (tmo_cnt == TMO_C) begin
                    // Entry edge is the first cycle of the pulse, hence preload 1
                    state_next = ST_PLL_RST;
                    cnt_next   = CNT_ONE;
                    tmo_next   = '0;
                end
            end

            ST_SDRAM_INIT, ST_RUN: begin
                if (!locked_s) begin
                    state_next  = ST_WAIT_LOCK;
                    cnt_next    = '0;
                    tmo_next    = '0;
                    relock_next = (relock_reg == '1) ? relock_reg : relock_reg + 1'b1;
                end else if (state_reg == ST_SDRAM_INIT) begin
                    if (cnt_reg + CNT_ONE == INIT_C) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            default: begin
                state_next = ST_PLL_RST;
                cnt_next   = '0;
                tmo_next   = '0;
            end
        endcase
    end

    // Outputs decode state_next so they switch on the same edge as the state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg         <= ST_PLL_RST;
            cnt_reg           <= '0;
            tmo_reg           <= '0;
            relock_reg        <= '0;
            pll_rst_reg       <= 1'b1;
            sdram_reset_n_reg <= 1'b0;
            sys_reset_n_reg   <= 1'b0;
            seq_ready_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            tmo_reg           <= tmo_next;
            relock_reg        <= relock_next;
            pll_rst_reg       <= (state_next == ST_PLL_RST);
            sdram_reset_n_reg <= (state_next == ST_SDRAM_INIT) || (state_next == ST_RUN);
            sys_reset_n_reg   <= (state_next == ST_RUN);
            seq_ready_reg     <= (state_next == ST_RUN);
        end
    end

    assign pll_rst       = pll_rst_reg;
    assign sdram_reset_n = sdram_reset_n_reg;
    assign sys_reset_n   = sys_reset_n_reg;
    assign seq_ready     = seq_ready_reg;
    assign relock_count  = relock_reg;
    assign seq_state     = state_reg;

endmodule

// File: tb/tb_platform_pll_reset_sequencer.sv
// Bench for the PLL reset sequencer: directed timing scenarios plus random
// lock/reset activity, all compared against a cycle-level behavioural model.
module tb_platform_pll_reset_sequencer;

    localparam int P_RST    = 4;
    localparam int P_STABLE = 8;
    localparam int P_INIT   = 20;
    localparam int P_TMO    = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sdram_reset_n;
    logic       sys_reset_n;
    logic       seq_ready;
    logic [7:0] relock_count;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: output levels plus the timers that move them
    bit m_pll_rst = 1'b1, m_sdram = 1'b0, m_sys = 1'b0;
    bit m_s1 = 1'b0, m_s2 = 1'b0;
    int m_pll_left = P_RST, m_run = 0, m_age = 0, m_init_left = 0, m_relocks = 0;

    always #10 clk = ~clk;

    platform_pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STABLE),
        .SDRAM_INIT_CYCLES  (P_INIT),
        .RELOCK_TIMEOUT     (P_TMO),
        .CNT_W              (21)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sdram_reset_n (sdram_reset_n),
        .sys_reset_n   (sys_reset_n),
        .seq_ready     (seq_ready),
        .relock_count  (relock_count),
        .seq_state     (seq_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {pll_rst, sdram_reset_n, sys_reset_n, seq_ready, seq_state, relock_count};
    endfunction

    function automatic logic [14:0] model_vec();
        logic [2:0] st;
        st = m_pll_rst ? 3'd0 : (!m_sdram ? 3'd1 : (!m_sys ? 3'd2 : 3'd3));
        return {m_pll_rst, m_sdram, m_sys, m_sys, st, 8'(m_relocks)};
    endfunction

    task automatic model_edge();
        bit ls;
        if (!reset_n) begin
            m_pll_rst = 1'b1; m_sdram = 1'b0; m_sys = 1'b0;
            m_s1 = 1'b0; m_s2 = 1'b0;
            m_pll_left = P_RST; m_run = 0; m_age = 0; m_init_left = 0; m_relocks = 0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (m_pll_rst) begin
                if (m_pll_left == 0) begin
                    m_pll_rst = 1'b0; m_run = 0; m_age = 0;
                end else begin
                    m_pll_left--;
                end
            end else if (!m_sdram) begin
                m_run = ls ? m_run + 1 : 0;
                m_age++;
                if (m_run == P_STABLE) begin
                    m_sdram = 1'b1; m_init_left = P_INIT;
                end else if (m_age == P_TMO) begin
                    m_pll_rst = 1'b1; m_pll_left = P_RST - 1;
                end
            end else if (!ls) begin
                m_sdram = 1'b0; m_sys = 1'b0; m_run = 0; m_age = 0;
                if (m_relocks < 255) m_relocks++;
            end else if (!m_sys) begin
                m_init_left--;
                if (m_init_left == 0) m_sys = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("outputs_vs_model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    initial begin
        int t_pll, t_sd, t_sys, t_fall;
        bit any_pll, prev_pll, reached;
        int rises[$];
        int falls[$];

        // Reset values
        reset_n = 1'b0;
        pll_locked = 1'b0;
        repeat (3) step();
        check_eq("reset_values", 32'(dut_vec()), 32'(15'b1_0_0_0_000_00000000));
        $display("txn reset: outputs 0x%0h", dut_vec());

        // Clean bring-up, lock from cycle 6
        reset_n = 1'b1;
        t_pll = -1; t_sd = -1; t_sys = -1;
        for (int e = 0; e < 45; e++) begin
            pll_locked = (e >= 6);
            step();
            if (t_pll < 0 && !pll_rst) t_pll = e;
            if (t_sd < 0 && sdram_reset_n) t_sd = e;
            if (t_sys < 0 && sys_reset_n) t_sys = e;
        end
        check_eq("bringup_pll_rst_fall", t_pll, 4);
        check_eq("bringup_sdram_rise", t_sd, 15);
        check_eq("bringup_sys_rise", t_sys, 35);
        check_eq("bringup_ready", seq_ready, 1);
        check_eq("bringup_relock", relock_count, 0);
        $display("txn bringup: pll_rst fall %0d, sdram %0d, sys %0d", t_pll, t_sd, t_sys);

        // Unstable lock: 5 high, 1 low, then steady
        reset_n = 1'b0; pll_locked = 1'b0;
        step();
        reset_n = 1'b1;
        t_sd = -1; t_sys = -1;
        for (int e = 0; e < 50; e++) begin
            pll_locked = (e >= 6 && e <= 10) || (e >= 12);
            step();
            if (t_sd < 0 && sdram_reset_n) t_sd = e;
            if (t_sys < 0 && sys_reset_n) t_sys = e;
        end
        check_eq("unstable_sdram_rise", t_sd, 21);
        check_eq("unstable_sys_rise", t_sys, 41);
        $display("txn unstable: sdram %0d, sys %0d", t_sd, t_sys);

        // One-cycle lock loss in RUN
        t_fall = -1; t_sd = -1; t_sys = -1; any_pll = 1'b0;
        for (int k = 0; k < 40; k++) begin
            pll_locked = (k != 0);
            step();
            if (pll_rst) any_pll = 1'b1;
            if (t_fall < 0 && !sdram_reset_n && !sys_reset_n) t_fall = k;
            if (t_fall >= 0 && t_sd < 0 && sdram_reset_n) t_sd = k;
            if (t_fall >= 0 && t_sys < 0 && sys_reset_n) t_sys = k;
        end
        check_eq("loss_resets_fall", t_fall, 2);
        check_eq("loss_sdram_rerise", t_sd, 10);
        check_eq("loss_sys_rerise", t_sys, 30);
        check_eq("loss_no_pll_rst", any_pll, 0);
        check_eq("loss_relock", relock_count, 1);
        $display("txn lockloss: fall %0d, sdram %0d, sys %0d", t_fall, t_sd, t_sys);

        // Timeout with lock held low
        prev_pll = pll_rst;
        pll_locked = 1'b0;
        for (int k = 0; k < 250; k++) begin
            step();
            if (pll_rst && !prev_pll) rises.push_back(k);
            if (!pll_rst && prev_pll) falls.push_back(k);
            prev_pll = pll_rst;
        end
        check_eq("timeout_rise_count", rises.size(), 2);
        check_eq("timeout_fall_count", falls.size(), 2);
        if (rises.size() >= 2 && falls.size() >= 2) begin
            check_eq("timeout_rise0", rises[0], 102);
            check_eq("timeout_fall0", falls[0], 106);
            check_eq("timeout_rise1", rises[1], 206);
            check_eq("timeout_fall1", falls[1], 210);
        end
        check_eq("timeout_relock", relock_count, 2);
        $display("txn timeout: %0d pulses", rises.size());

        // Reset in the middle of SDRAM_INIT
        pll_locked = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 300 && !reached; k++) begin
            step();
            reached = sdram_reset_n && !sys_reset_n;
        end
        check_eq("midinit_reached", reached, 1);
        repeat (5) step();
        reset_n = 1'b0;
        step();
        check_eq("midinit_reset_values", 32'(dut_vec()), 32'(15'b1_0_0_0_000_00000000));
        reset_n = 1'b1;
        t_pll = -1;
        for (int e = 0; e < 10; e++) begin
            step();
            if (t_pll < 0 && !pll_rst) t_pll = e;
        end
        check_eq("midinit_pll_rst_fall", t_pll, 4);
        $display("txn midinit_reset: pll_rst fall %0d", t_pll);

        // Random lock activity with occasional reset pulses
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 250) : $urandom_range(1, 30);
            pll_locked = $urandom_range(0, 2) != 0;
            reset_n = ($urandom_range(0, 40) != 0);
            for (int k = 0; k < len; k++) begin
                step();
                reset_n = 1'b1;
            end
        end
        $display("txn random: relock_count %0d", relock_count);

        // Relock counter saturation
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int ev = 0; ev < 260; ev++) begin
            pll_locked = 1'b1;
            reached = 1'b0;
            for (int k = 0; k < 60 && !reached; k++) begin
                step();
                reached = sdram_reset_n;
            end
            if (!reached) begin
                check_eq("sat_wait_sdram", 0, 1);
                break;
            end
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            step();
            step();
        end
        check_eq("sat_relock", relock_count, 255);
        $display("txn saturation: relock_count %0d", relock_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/platform_pll_reset_sequencer.md
# platform_pll_reset_sequencer

Reset sequencer sitting directly downstream of the platform system PLL. It drives the PLL reset, qualifies the PLL `locked` output, and releases the SDRAM-controller reset and then the system reset in a fixed order with timed gaps. On lock loss it re-asserts both resets, and if lock does not return in time it re-resets the PLL. It runs on the 50 MHz board reference clock, which is valid whether or not the PLL is locked.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before lock is accepted.
- `SDRAM_INIT_CYCLES`, 10000: gap between `sdram_reset_n` release and `sys_reset_n` release (200 µs at 50 MHz).
- `RELOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_LOCK before the PLL is reset again.
- `CNT_W`, 21: shared down/up counter width. All cycle parameters must be ≥1 and ≤ 2^CNT_W−1.
- `clk`  in  1  board reference clock, 50 MHz, same net as the PLL refclk.
- `reset_n`  in  1  reset; synchronous, active-low.
- `pll_locked`  in  1  PLL lock; asynchronous to `clk`.
- `pll_rst`  out  1  PLL reset, active-high.
- `sdram_reset_n`  out  1  SDRAM controller reset, active-low.
- `sys_reset_n`  out  1  system reset, active-low.
- `seq_ready`  out  1  high only in RUN.
- `relock_count`  out  8  count of lock losses, saturating at 255.
- `seq_state`  out  3  current FSM state encoding, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to form `locked_s`. All decisions use `locked_s`.
- FSM states: PLL_RST=0, WAIT_LOCK=1, SDRAM_INIT=2, RUN=3.
- **PLL_RST**
  - `pll_rst`=1; counter counts PLL_RST_CYCLES cycles.
  - Then go to WAIT_LOCK and clear the counters.
- **WAIT_LOCK**
  - `pll_rst`=0.
  - Stable counter increments while `locked_s`=1 and clears to 0 on any `locked_s`=0.
  - Reaching LOCK_STABLE_CYCLES → SDRAM_INIT.
  - Timeout counter increments every cycle in this state. Reaching RELOCK_TIMEOUT → PLL_RST.
  - If stable and timeout thresholds are hit in the same cycle, stable wins.
- **SDRAM_INIT**
  - `sdram_reset_n`=1.
  - Counts SDRAM_INIT_CYCLES, then goes to RUN.
- **RUN**
  - `sdram_reset_n`=1, `sys_reset_n`=1, `seq_ready`=1.
- **Lock loss**
  - `locked_s`=0 in SDRAM_INIT or RUN → WAIT_LOCK, with both resets asserted and `seq_ready`=0.
  - `relock_count` increments (saturating 255→255).
  - The PLL is not reset unless RELOCK_TIMEOUT then expires.
- **Reset**
  - `reset_n`=0 in any state, including mid-sequence, forces the reset values below on the next edge.
  - It also clears all counters and the synchronizer.
- **Reset values**
  - `pll_rst`=1, `sdram_reset_n`=0, `sys_reset_n`=0, `seq_ready`=0, `relock_count`=0, `seq_state`=PLL_RST.

## Timing
- All outputs are registered and decoded from next-state, so each output changes on the same edge as the state change. No combinational input→output paths.
- `pll_rst` pulse width:
  - Exactly PLL_RST_CYCLES cycles from the first edge with `reset_n`=1.
  - Same width when re-entered via timeout.
- Lock acceptance:
  - `sdram_reset_n` rises LOCK_STABLE_CYCLES cycles after the first edge where `locked_s`=1, provided lock stayed high throughout.
  - `locked_s` lags `pll_locked` by 2 edges.
- `sys_reset_n` and `seq_ready` rise exactly SDRAM_INIT_CYCLES cycles after `sdram_reset_n` rises.
- Lock-loss response:
  - `pll_locked` falling to both resets low takes 3 edges (2 sync + 1 register).
  - A lock glitch of ≥1 sampled cycle always triggers this response; there is no glitch filtering on loss.

## Structure
- Package `platform_reset_pkg`:
  - `seq_state_t` enum with the four encodings above.
  - `RELOCK_CNT_W`=8.
- Sub-module `platform_sync_2ff`: 1-bit two-flop synchronizer with reset value 0, reusable elsewhere in the platform.
- The FSM and counters live in the top module. A single shared counter is allowed, since only one timed phase is active at a time; the timeout counter is separate.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, SDRAM_INIT_CYCLES=20, RELOCK_TIMEOUT=100.
- **Clean bring-up.** Release `reset_n`; `pll_locked`=1 from cycle 6 onward.
  - `pll_rst` is high in cycles 0–3 and low from cycle 4.
  - `sdram_reset_n` rises 8 cycles after `locked_s` rises.
  - `sys_reset_n` and `seq_ready` rise 20 cycles later.
  - `relock_count`=0.
- **Unstable lock.** Lock high for 5 cycles, low for 1, then steady high.
  - The stable counter restarts at the drop.
  - `sdram_reset_n` rises 8 cycles after the second rise of `locked_s`.
- **Lock loss in RUN.** Drop `pll_locked` for 1 cycle.
  - Both resets go low 3 edges later; `relock_count`=1; `pll_rst` stays 0.
  - Full re-release follows after 8+20 cycles.
- **Timeout.** Hold `pll_locked`=0.
  - `pll_rst` re-asserts for 4 cycles after 100 cycles in WAIT_LOCK, and repeats periodically.
- **Reset mid-SDRAM_INIT.** Pulse `reset_n` low.
  - All outputs return to reset values on the next edge.
  - The sequence restarts from PLL_RST.
- **Saturation.** 260 lock-loss events → `relock_count` reads 255.
